// File: rtl/hpdcache_mshr_ctrl_if.sv
`default_nettype none
// ============================================================================
// hpdcache_mshr_ctrl_if : miss / memory / refill / MSHR port bundle
// Revision: 1.0
// ============================================================================
interface hpdcache_mshr_ctrl_if #(
    parameter int NLINE_W    = 32,
    parameter int SET_W      = 7,
    parameter int MSHR_SET_W = 1,
    parameter int MSHR_WAY_W = 2,
    parameter int META_W     = 24
);
    localparam int ID_W = MSHR_WAY_W + MSHR_SET_W;

    logic                      miss_valid_i;
    logic                      miss_ready_o;
    logic [NLINE_W-1:0]        miss_nline_i;
    logic [META_W-1:0]         miss_meta_i;
    logic                      miss_rsp_valid_o;
    logic [1:0]                miss_rsp_status_o;
    logic [ID_W-1:0]           miss_rsp_id_o;
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [NLINE_W-1:0]        mem_req_nline_o;
    logic [ID_W-1:0]           mem_req_id_o;
    logic                      refill_valid_i;
    logic                      refill_ready_o;
    logic [ID_W-1:0]           refill_id_i;
    logic                      ack_valid_o;
    logic [ID_W-1:0]           ack_id_o;
    logic                      mshr_check_o;
    logic [SET_W-1:0]          mshr_check_set_o;
    logic [NLINE_W-SET_W-1:0]  mshr_check_tag_o;
    logic                      mshr_hit_i;
    logic                      mshr_alloc_full_i;
    logic [MSHR_WAY_W-1:0]     mshr_alloc_way_i;
    logic                      mshr_alloc_o;
    logic                      mshr_alloc_cs_o;
    logic [NLINE_W-1:0]        mshr_alloc_nline_o;
    logic [META_W-1:0]         mshr_alloc_meta_o;
    logic                      mshr_ack_o;
    logic                      mshr_ack_cs_o;
    logic [MSHR_SET_W-1:0]     mshr_ack_set_o;
    logic [MSHR_WAY_W-1:0]     mshr_ack_way_o;

    // master: the sequencer itself
    modport master (
        input  miss_valid_i, miss_nline_i, miss_meta_i, mem_req_ready_i,
               refill_valid_i, refill_id_i, mshr_hit_i, mshr_alloc_full_i,
               mshr_alloc_way_i,
        output miss_ready_o, miss_rsp_valid_o, miss_rsp_status_o, miss_rsp_id_o,
               mem_req_valid_o, mem_req_nline_o, mem_req_id_o, refill_ready_o,
               ack_valid_o, ack_id_o, mshr_check_o, mshr_check_set_o,
               mshr_check_tag_o, mshr_alloc_o, mshr_alloc_cs_o,
               mshr_alloc_nline_o, mshr_alloc_meta_o, mshr_ack_o,
               mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o
    );

    modport slave (
        output miss_valid_i, miss_nline_i, miss_meta_i, mem_req_ready_i,
               refill_valid_i, refill_id_i, mshr_hit_i, mshr_alloc_full_i,
               mshr_alloc_way_i,
        input  miss_ready_o, miss_rsp_valid_o, miss_rsp_status_o, miss_rsp_id_o,
               mem_req_valid_o, mem_req_nline_o, mem_req_id_o, refill_ready_o,
               ack_valid_o, ack_id_o, mshr_check_o, mshr_check_set_o,
               mshr_check_tag_o, mshr_alloc_o, mshr_alloc_cs_o,
               mshr_alloc_nline_o, mshr_alloc_meta_o, mshr_ack_o,
               mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o
    );
endinterface
`default_nettype wire

// File: rtl/hpdcache_mshr_ctrl.sv
`default_nettype none
// ============================================================================
// hpdcache_mshr_ctrl : single-ported MSHR sequencer (check / alloc / ack)
// Revision: 1.0
// ============================================================================
module hpdcache_mshr_ctrl #(
    parameter int NLINE_W       = 32,
    parameter int SET_W         = 7,
    parameter int MSHR_SET_W    = 1,
    parameter int MSHR_WAY_W    = 2,
    parameter int META_W        = 24,
    parameter int ACK_BURST_MAX = 4
) (
    input wire logic             clk_i,
    input wire logic             rst_ni,
    hpdcache_mshr_ctrl_if.master bus
);
    localparam int ID_W  = MSHR_WAY_W + MSHR_SET_W;
    localparam int TAG_W = NLINE_W - SET_W;
    localparam int CNT_W = $clog2(ACK_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_BURST_MAX);

    localparam logic [1:0] RSP_ALLOC = 2'd0;
    localparam logic [1:0] RSP_HIT   = 2'd1;
    localparam logic [1:0] RSP_FULL  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        ALLOC  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    ack_cnt;
    logic [NLINE_W-1:0]  nline_q;
    logic [META_W-1:0]   meta_q;
    logic                rsp_valid_q;
    logic [1:0]          rsp_status_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                ack_valid_q;
    logic [ID_W-1:0]     ack_id_q;

    logic                miss_grant;
    logic                ack_grant;
    logic                rsp_fire;
    logic [1:0]          rsp_status_nx;
    logic                in_alloc;
    logic                alloc_fire;
    logic [ID_W-1:0]     alloc_id;

    assign in_alloc   = (state == ALLOC);
    assign alloc_fire = in_alloc && bus.mem_req_ready_i;
    assign alloc_id   = {bus.mshr_alloc_way_i, nline_q[MSHR_SET_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grants are masked during reset so every output reads 0 while rst_ni is low.
    always_comb begin
        state_nx      = state;
        miss_grant    = 1'b0;
        ack_grant     = 1'b0;
        rsp_fire      = 1'b0;
        rsp_status_nx = RSP_ALLOC;
        case (state)
            IDLE: begin
                miss_grant = bus.miss_valid_i &&
                             (!bus.refill_valid_i || (ack_cnt == CNT_MAX));
                ack_grant  = bus.refill_valid_i && !miss_grant;
                if (miss_grant) begin
                    state_nx = DECIDE;
                end
            end
            DECIDE: begin
                ack_grant = bus.refill_valid_i;
                if (bus.mshr_hit_i) begin
                    rsp_fire      = 1'b1;
                    rsp_status_nx = RSP_HIT;
                    state_nx      = IDLE;
                end else if (bus.mshr_alloc_full_i) begin
                    rsp_fire      = 1'b1;
                    rsp_status_nx = RSP_FULL;
                    state_nx      = IDLE;
                end else begin
                    state_nx = ALLOC;
                end
            end
            ALLOC: begin
                if (bus.mem_req_ready_i) begin
                    rsp_fire      = 1'b1;
                    rsp_status_nx = RSP_ALLOC;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!rst_ni) begin
            miss_grant = 1'b0;
            ack_grant  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_cnt      <= '0;
            nline_q      <= '0;
            meta_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_id_q     <= '0;
            ack_valid_q  <= 1'b0;
            ack_id_q     <= '0;
        end else begin
            if (miss_grant) begin
                nline_q <= bus.miss_nline_i;
                meta_q  <= bus.miss_meta_i;
            end
            // Saturating burst counter; DECIDE-state acks cannot push it past the limit.
            if (!bus.miss_valid_i || miss_grant) begin
                ack_cnt <= '0;
            end else if (ack_grant && (ack_cnt != CNT_MAX)) begin
                ack_cnt <= ack_cnt + 1'b1;
            end
            rsp_valid_q <= rsp_fire;
            if (rsp_fire) begin
                rsp_status_q <= rsp_status_nx;
                rsp_id_q     <= in_alloc ? alloc_id : '0;
            end
            ack_valid_q <= ack_grant;
            if (ack_grant) begin
                ack_id_q <= bus.refill_id_i;
            end
        end
    end

    always_comb begin
        bus.mshr_check_set_o = '0;
        bus.mshr_check_tag_o = '0;
        if (state == DECIDE) begin
            bus.mshr_check_set_o = nline_q[SET_W-1:0];
            bus.mshr_check_tag_o = nline_q[NLINE_W-1:SET_W];
        end else if (miss_grant) begin
            bus.mshr_check_set_o = bus.miss_nline_i[SET_W-1:0];
            bus.mshr_check_tag_o = bus.miss_nline_i[NLINE_W-1:SET_W];
        end
    end

    assign bus.miss_ready_o       = miss_grant;
    assign bus.mshr_check_o       = miss_grant;
    assign bus.miss_rsp_valid_o   = rsp_valid_q;
    assign bus.miss_rsp_status_o  = rsp_status_q;
    assign bus.miss_rsp_id_o      = rsp_id_q;

    assign bus.mem_req_valid_o    = in_alloc;
    assign bus.mem_req_nline_o    = nline_q;
    assign bus.mem_req_id_o       = in_alloc ? alloc_id : '0;
    assign bus.mshr_alloc_o       = alloc_fire;
    assign bus.mshr_alloc_cs_o    = alloc_fire;
    assign bus.mshr_alloc_nline_o = nline_q;
    assign bus.mshr_alloc_meta_o  = meta_q;

    assign bus.refill_ready_o     = ack_grant;
    assign bus.mshr_ack_o         = ack_grant;
    assign bus.mshr_ack_cs_o      = ack_grant;
    assign bus.mshr_ack_set_o     = ack_grant ? bus.refill_id_i[MSHR_SET_W-1:0] : '0;
    assign bus.mshr_ack_way_o     = ack_grant ? bus.refill_id_i[ID_W-1:MSHR_SET_W] : '0;
    assign bus.ack_valid_o        = ack_valid_q;
    assign bus.ack_id_o           = ack_id_q;

    // TAG_W documents the check-tag width carried on the interface.
    if (TAG_W < 1) begin : g_bad_widths
        $error("NLINE_W must exceed SET_W");
    end
endmodule
`default_nettype wire

// File: doc/hpdcache_mshr_ctrl.md
# hpdcache_mshr_ctrl

Sequencer for the single-ported HPDcache MSHR. It accepts one primary-miss request at a time, runs the MSHR check, and either allocates an entry while issuing the memory read, or reports a secondary miss or full. It also accepts refill acknowledgements from the memory-response path and arbitrates them against miss traffic. It guarantees that check, alloc and ack never coincide.

## Interface
Parameters:
- NLINE_W, 32: cache-line number width. Cache set index is nline[SET_W-1:0]; tag is nline[NLINE_W-1:SET_W].
- SET_W, 7: cache set index width.
- MSHR_SET_W, 1: MSHR set width. The MSHR set is nline[MSHR_SET_W-1:0], or 0 when the MSHR has 1 set.
- MSHR_WAY_W, 2: MSHR way index width.
- META_W, 24: packed alloc metadata width {tid, sid, word, victim_way, need_rsp, is_prefetch, wback}. It is opaque to this block.
- ACK_BURST_MAX, 4: maximum number of consecutive ack grants while a miss waits (≥1).

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- miss_valid_i / miss_ready_o, in/out, 1: miss request handshake.
- miss_nline_i, in, NLINE_W: missing line.
- miss_meta_i, in, META_W: alloc metadata.
- miss_rsp_valid_o, out, 1: one-cycle result pulse.
- miss_rsp_status_o, out, 2: 0 = ALLOC, 1 = HIT (secondary miss, replay), 2 = FULL.
- miss_rsp_id_o, out, MSHR_WAY_W+MSHR_SET_W: {way, set} of the allocated entry. Valid only when status is ALLOC.
- mem_req_valid_o / mem_req_ready_i, out/in, 1: memory read request handshake.
- mem_req_nline_o, out, NLINE_W: line to read.
- mem_req_id_o, out, MSHR_WAY_W+MSHR_SET_W: {way, set} transaction id.
- refill_valid_i / refill_ready_o, in/out, 1: refill acknowledge handshake.
- refill_id_i, in, MSHR_WAY_W+MSHR_SET_W: entry to release.
- ack_valid_o, out, 1: MSHR ack read data valid this cycle. Downstream samples the MSHR ack_* outputs.
- ack_id_o, out, MSHR_WAY_W+MSHR_SET_W: id belonging to ack_valid_o.
- mshr_check_o, out, 1: MSHR check.
- mshr_check_set_o, out, SET_W: cache set for check.
- mshr_check_tag_o, out, NLINE_W-SET_W: tag for check.
- mshr_hit_i, in, 1: MSHR hit.
- mshr_alloc_full_i, in, 1: MSHR alloc full.
- mshr_alloc_way_i, in, MSHR_WAY_W: MSHR alloc way.
- mshr_alloc_o, out, 1: MSHR alloc.
- mshr_alloc_cs_o, out, 1: MSHR alloc chip select.
- mshr_alloc_nline_o, out, NLINE_W: registered copy of the miss line.
- mshr_alloc_meta_o, out, META_W: registered copy of the miss metadata.
- mshr_ack_o, out, 1: MSHR ack.
- mshr_ack_cs_o, out, 1: MSHR ack chip select.
- mshr_ack_set_o, out, MSHR_SET_W: ack set (from refill_id_i).
- mshr_ack_way_o, out, MSHR_WAY_W: ack way (from refill_id_i).

## Operation
- States: IDLE, DECIDE, ALLOC.
- IDLE: exactly one grant per cycle, chosen between miss and refill.
  - Refill wins by default.
  - Miss wins when ack_cnt == ACK_BURST_MAX.
  - ack_cnt increments on each refill grant while miss_valid_i=1. It clears on a miss grant or whenever miss_valid_i=0.
- Miss grant (IDLE):
  - miss_ready_o=1, mshr_check_o=1, check set/tag taken combinationally from miss_nline_i.
  - nline and meta are registered. Next state is DECIDE.
- DECIDE:
  - mshr_check_set_o and mshr_check_tag_o are driven from the registered nline, because hit is computed this cycle.
  - hit=1 → rsp HIT, next state IDLE.
  - Else alloc_full=1 → rsp FULL, next state IDLE.
  - Else → next state ALLOC.
  - Hit takes precedence over full.
  - refill_ready_o may be 1 in DECIDE; the ack is granted here.
- ALLOC:
  - mem_req_valid_o=1, held stable until ready.
  - mem_req_id_o = {mshr_alloc_way_i, registered MSHR set}.
  - mshr_alloc_o = mshr_alloc_cs_o = mem_req_ready_i, so the alloc fires exactly on the handshake cycle.
  - On the handshake: rsp ALLOC with the id latched that cycle, next state IDLE.
  - refill_ready_o=0 in ALLOC.
- Refill grant:
  - refill_ready_o=1, mshr_ack_o = mshr_ack_cs_o = 1, set/way taken from refill_id_i.
  - ack_valid_o and ack_id_o are registered copies, asserted the next cycle.
- Invariant: mshr_ack_o is never asserted together with mshr_check_o or mshr_alloc_o.
- The block itself never backpressures responses: miss_rsp_valid_o has no ready.

## Timing
- Reset values:
  - All outputs 0, state IDLE, ack_cnt 0, registered nline/meta 0.
  - Reset asserted mid-operation aborts the miss with no response and drops mem_req_valid_o immediately.
- Miss latency, T = miss handshake cycle:
  - HIT/FULL: rsp at T+2, next miss accepted at T+2 at the earliest.
  - ALLOC with ready at T+2: alloc and mem handshake at T+2, rsp at T+3.
- Each extra cycle of mem_req_ready_i=0 adds one cycle to the ALLOC latency.
- Ack: granted at cycle A, ack_valid_o at A+1. Back-to-back acks are sustainable in IDLE.
- All miss_rsp_* and ack_* outputs are registered. mshr_* control outputs are combinational from state and inputs.

## Test plan
- Empty MSHR, miss nline=0x1234 (SET_W=7), mem ready=1:
  - Check at T with set 0x34, tag 0x24.
  - Alloc and mem_req at T+2 with id {way 0, set 0}.
  - rsp ALLOC at T+3.
- Second miss 0x1234 after the first alloc: mshr_hit_i=1 at T+1 → rsp HIT at T+2, no mem_req, no alloc.
- MSHR full (alloc_full=1, hit=0) → rsp FULL at T+2.
  - Then refill id {1,0} → ack_valid_o with ack_id_o={1,0} one cycle later.
  - A retried miss then allocates.
- Continuous refill_valid_i plus a pending miss, ACK_BURST_MAX=4:
  - Exactly 4 acks are granted, then the miss is granted.
  - No cycle ever has ack together with check or alloc.
- mem_req_ready_i low for 5 cycles in ALLOC:
  - mem_req_valid_o, nline and id stay stable.
  - Single alloc pulse on the ready cycle; refills are blocked throughout ALLOC.
- rst_ni asserted while in ALLOC: all outputs 0 asynchronously. After release, state is IDLE and no rsp is emitted.
